// File: rtl/matrix_mac_2x2.sv
// 2x2 block multiply-accumulate (C += A*B) for the matrix-multiply control unit.
// One shared multiplier walks the 8 partial products; each product is accumulated one edge later.
module matrix_mac_2x2 #(
  parameter int data_w = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_mac,
  input  logic              clear_acc,
  input  logic              acc_clr,
  input  logic [data_w-1:0] a_11,
  input  logic [data_w-1:0] a_12,
  input  logic [data_w-1:0] a_21,
  input  logic [data_w-1:0] a_22,
  input  logic [data_w-1:0] b_11,
  input  logic [data_w-1:0] b_12,
  input  logic [data_w-1:0] b_21,
  input  logic [data_w-1:0] b_22,
  output logic [data_w-1:0] c_11,
  output logic [data_w-1:0] c_12,
  output logic [data_w-1:0] c_21,
  output logic [data_w-1:0] c_22,
  output logic              done_mac,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: start_mac is a level request; a rising edge seen in IDLE is accepted once,
  // the operands are captured on that edge, and done_mac pulses one cycle when C is final.
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, ACC_LAST = 2'd2} state_t;

  state_t            state;
  logic [2:0]        step;
  logic [data_w-1:0] p;
  logic              start_prev;
  logic              l_clr;
  logic [data_w-1:0] l_a11, l_a12, l_a21, l_a22;
  logic [data_w-1:0] l_b11, l_b12, l_b21, l_b22;

  logic [data_w-1:0] op_x, op_y, prod;
  logic [2:0]        acc_idx;
  logic [data_w-1:0] acc_cur, acc_new;
  logic              acc_en;
  logic              accept;

  assign state_dbg = state;
  assign accept    = (state == IDLE) && start_mac && !start_prev;

  always_comb begin
    op_x = l_a11;
    op_y = l_b11;
    case (step)
      3'd0: begin op_x = l_a11; op_y = l_b11; end
      3'd1: begin op_x = l_a12; op_y = l_b21; end
      3'd2: begin op_x = l_a11; op_y = l_b12; end
      3'd3: begin op_x = l_a12; op_y = l_b22; end
      3'd4: begin op_x = l_a21; op_y = l_b11; end
      3'd5: begin op_x = l_a22; op_y = l_b21; end
      3'd6: begin op_x = l_a21; op_y = l_b12; end
      default: begin op_x = l_a22; op_y = l_b22; end
    endcase
  end

  assign prod = op_x * op_y;

  // p holds the term of the previous step; step wraps 7->0 entering ACC_LAST, so step-1 is 7 there.
  assign acc_idx = step - 3'd1;
  assign acc_en  = ((state == MUL) && (step != 3'd0)) || (state == ACC_LAST);

  always_comb begin
    acc_cur = c_11;
    case (acc_idx[2:1])
      2'd0: acc_cur = c_11;
      2'd1: acc_cur = c_12;
      2'd2: acc_cur = c_21;
      default: acc_cur = c_22;
    endcase
    acc_new = (l_clr && !acc_idx[0]) ? p : acc_cur + p;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step       <= 3'd0;
      p          <= '0;
      start_prev <= 1'b0;
      l_clr      <= 1'b0;
      l_a11 <= '0; l_a12 <= '0; l_a21 <= '0; l_a22 <= '0;
      l_b11 <= '0; l_b12 <= '0; l_b21 <= '0; l_b22 <= '0;
      c_11 <= '0; c_12 <= '0; c_21 <= '0; c_22 <= '0;
      done_mac <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start_prev <= start_mac;
      done_mac   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            l_a11 <= a_11; l_a12 <= a_12; l_a21 <= a_21; l_a22 <= a_22;
            l_b11 <= b_11; l_b12 <= b_12; l_b21 <= b_21; l_b22 <= b_22;
            l_clr <= clear_acc;
            step  <= 3'd0;
            busy  <= 1'b1;
            state <= MUL;
          end else if (acc_clr) begin
            c_11 <= '0; c_12 <= '0; c_21 <= '0; c_22 <= '0;
          end
        end
        MUL: begin
          p    <= prod;
          step <= step + 3'd1;
          if (step == 3'd7) state <= ACC_LAST;
        end
        ACC_LAST: begin
          done_mac <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (acc_en) begin
        case (acc_idx[2:1])
          2'd0: c_11 <= acc_new;
          2'd1: c_12 <= acc_new;
          2'd2: c_21 <= acc_new;
          default: c_22 <= acc_new;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_mac_2x2.sv
// Directed bench for matrix_mac_2x2: hand-computed C blocks, latency, busy window,
// held start, mid-run reset and accumulator clear.
module tb_matrix_mac_2x2;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_mac = 1'b0, clear_acc = 1'b0, acc_clr = 1'b0;
  logic [W-1:0] a_11 = '0, a_12 = '0, a_21 = '0, a_22 = '0;
  logic [W-1:0] b_11 = '0, b_12 = '0, b_21 = '0, b_22 = '0;
  logic [W-1:0] c_11, c_12, c_21, c_22;
  logic         done_mac, busy;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  matrix_mac_2x2 #(.data_w(W)) dut (
    .clk(clk), .rst(rst), .start_mac(start_mac), .clear_acc(clear_acc), .acc_clr(acc_clr),
    .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
    .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
    .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22),
    .done_mac(done_mac), .busy(busy), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [W-1:0] e11, e12, e21, e22);
    chk({tag, ".c11"}, c_11, e11);
    chk({tag, ".c12"}, c_12, e12);
    chk({tag, ".c21"}, c_21, e21);
    chk({tag, ".c22"}, c_22, e22);
  endtask

  task automatic set_ops(input logic [W-1:0] x11, x12, x21, x22, y11, y12, y21, y22);
    a_11 = x11; a_12 = x12; a_21 = x21; a_22 = x22;
    b_11 = y11; b_12 = y12; b_21 = y21; b_22 = y22;
  endtask

  // One start pulse; returns at the negedge where done_mac is seen (or after the bound).
  task automatic run_block(input logic [W-1:0] x11, x12, x21, x22, y11, y12, y21, y22,
                           input logic clr, input logic acl, output int lat, output int bcnt);
    @(negedge clk);
    set_ops(x11, x12, x21, x22, y11, y12, y21, y22);
    clear_acc = clr;
    acc_clr   = acl;
    start_mac = 1'b1;
    @(negedge clk);
    start_mac = 1'b0;
    acc_clr   = 1'b0;
    bcnt = int'(busy);
    lat  = 0;
    while (!done_mac && lat < 20) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy);
    end
  endtask

  int lat, bcnt, dones;

  initial begin
    // reset state
    #12;
    chk_c("rst", 0, 0, 0, 0);
    chk("rst.done", {31'b0, done_mac}, 0);
    chk("rst.busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst = 1'b1;

    // case 1: overwrite
    run_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b0, lat, bcnt);
    chk("t1.latency", lat, 9);
    chk("t1.busy_cycles", bcnt, 9);
    chk("t1.busy_after", {31'b0, busy}, 0);
    chk_c("t1", 19, 22, 43, 50);
    @(negedge clk);
    chk("t1.done_one_cycle", {31'b0, done_mac}, 0);

    // case 2: accumulate
    run_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b0, 1'b0, lat, bcnt);
    chk("t2.latency", lat, 9);
    chk_c("t2", 38, 44, 86, 100);
    @(negedge clk);
    chk_c("t2.hold", 38, 44, 86, 100);

    // case 3: wrap-around
    run_block(32'hFFFF_FFFF, 0, 0, 0, 2, 0, 0, 0, 1'b1, 1'b0, lat, bcnt);
    chk_c("t3", 32'hFFFF_FFFE, 0, 0, 0);

    // case 4: held start, operand changes mid-run
    @(negedge clk);
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    clear_acc = 1'b1;
    start_mac = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        set_ops(9, 9, 9, 9, 9, 9, 9, 9);
        clear_acc = 1'b0;
      end
      dones += int'(done_mac);
    end
    chk("t4.held_dones", dones, 1);
    chk_c("t4.held", 19, 22, 43, 50);
    start_mac = 1'b0;
    @(negedge clk);
    set_ops(2, 0, 0, 2, 1, 2, 3, 4);
    clear_acc = 1'b1;
    start_mac = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done_mac && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t4.reraise_latency", lat, 9);
    chk_c("t4.reraise", 2, 4, 6, 8);
    start_mac = 1'b0;

    // case 5: reset at E5
    @(negedge clk);
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    clear_acc = 1'b1;
    start_mac = 1'b1;
    @(negedge clk);
    start_mac = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5.busy_before", {31'b0, busy}, 1);
    rst = 1'b0;
    #1;
    chk_c("t5.rst", 0, 0, 0, 0);
    chk("t5.rst.busy", {31'b0, busy}, 0);
    chk("t5.rst.done", {31'b0, done_mac}, 0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dones += int'(done_mac);
    end
    chk("t5.no_done", dones, 0);
    run_block(1, 1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0, lat, bcnt);
    chk("t5.after_latency", lat, 9);
    chk_c("t5.after", 2, 2, 2, 2);

    // case 6: acc_clr in IDLE, then acc_clr coinciding with acceptance
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk_c("t6.clr", 0, 0, 0, 0);
    run_block(1, 1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0, lat, bcnt);
    chk_c("t6.refill", 2, 2, 2, 2);
    run_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b0, 1'b1, lat, bcnt);
    chk("t6.accept_latency", lat, 9);
    chk_c("t6.accept_wins", 21, 24, 45, 52);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_mac_2x2.md
Name: matrix_mac_2x2

Overview:
- Downstream compute stage of the matrix-multiply control unit.
- Accepts one 2x2 A block (a_11..a_22) and one 2x2 B block (b_11..b_22) per start_mac, and accumulates C += A*B into four internal accumulators.
- Returns c_11..c_22 and a one-cycle done_mac to the control unit.
- Uses one shared multiplier, time-multiplexed over 8 partial products, to keep area small for the block-multiply loop over k.

Parameters:
data_w, 32, width of every operand, product and accumulator word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start_mac  in  1  start request from control unit; may be held high
clear_acc  in  1  sampled at acceptance; 1 means the first term of each c_xy overwrites instead of adding (first k block)
acc_clr  in  1  synchronous zeroing of all accumulators; honoured only in IDLE
a_11,a_12,a_21,a_22  in  data_w  A block operands, sampled at acceptance
b_11,b_12,b_21,b_22  in  data_w  B block operands, sampled at acceptance
c_11,c_12,c_21,c_22  out  data_w  accumulator contents
done_mac  out  1  one-cycle pulse; C final for this block
busy  out  1  high from the edge after acceptance to the final accumulate edge

Behaviour:
- Reset (rst=0, async):
  - c_* = 0, done_mac = 0, busy = 0.
  - Step counter = 0, product register = 0, start_prev = 0, state = IDLE.
  - Reset mid-operation aborts immediately; no done_mac is produced.
- Acceptance (edge E0):
  - Condition: state IDLE, start_mac=1, start_prev=0. start_prev is the registered start_mac, so start_mac held high out of reset counts as a rising edge.
  - A level-held start_mac triggers exactly once. A new block needs start_mac low for at least one cycle.
  - At E0: latch all 8 operands and clear_acc; step=0; go to MUL.
  - start_mac while busy is ignored; the operand latches do not change.
- acc_clr in IDLE without acceptance: c_* <= 0 at that edge. If acc_clr and acceptance coincide, acceptance wins and acc_clr is ignored.
- Schedule (edges E1..E8): product register p <= low data_w bits of op_x*op_y for step s=0..7, then s increments.
  - s0 a11*b11 -> c11
  - s1 a12*b21 -> c11
  - s2 a11*b12 -> c12
  - s3 a12*b22 -> c12
  - s4 a21*b11 -> c21
  - s5 a22*b21 -> c21
  - s6 a21*b12 -> c22
  - s7 a22*b22 -> c22
- Accumulate (edges E2..E9): target <= target + p, using the term from the previous edge.
  - For even s with latched clear_acc=1: target <= p instead.
- Arithmetic: all modulo 2^data_w; wrap-around is silent, with no saturation or overflow flag. Signed and unsigned results are identical in the low bits.
- States:
  - IDLE -> MUL on acceptance.
  - MUL runs for E1..E8.
  - ACC_LAST at E9 performs the final accumulate, sets done_mac=1 and busy=0, and returns to IDLE.
  - done_mac is high exactly one cycle, the cycle after E9. c_* then hold the final values and stay stable until the next acceptance or acc_clr.
- Latency: done_mac high 9 edges after the acceptance edge. Back-to-back throughput is one block per 10 cycles (start_mac low for one cycle between blocks).
- busy = 1 after E0 through E8; 0 after E9.
- c_* are visible while accumulating. Partial values are not guaranteed meaningful until done_mac.

Test Plan:
1. Reset, then A=[1,2;3,4], B=[5,6;7,8], clear_acc=1, start_mac pulse -> done_mac 9 edges later for exactly one cycle; C=[19,22;43,50]; busy high 9 cycles.
2. Repeat the same operands with clear_acc=0 after case 1 -> C=[38,44;86,100].
3. a_11=0xFFFFFFFF, b_11=2, all other operands 0, clear_acc=1 -> c_11=0xFFFFFFFE; c_12, c_21, c_22 = 0.
4. start_mac held high for 30 cycles -> exactly one done_mac. Change operands mid-run -> result uses the values latched at E0. Drop start_mac for 1 cycle and reraise -> second block accepted.
5. Deassert rst at E5 of a run -> all outputs 0 immediately, no done_mac. The next start_mac works normally.
6. acc_clr=1 in IDLE with C nonzero -> C=0 at the next edge. acc_clr together with acceptance -> acceptance proceeds and acc_clr is ignored.
